cdr_lock_detector: RTL

- Downstream consumer of the CDR loop's signed 8-bit phase error output.
- Accumulates windowed statistics on |phase_error| and runs a lock-qualification FSM (unlocked / acquiring / locked / holdover).
- Produces a lock flag, state, per-window quality metrics and a saturating loss-of-lock counter for logging and for the system controller.

---
 rtl/cdr_lock_detector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cdr_lock_detector.sv
// rtl/cdr_lock_detector.sv - CDR phase-error window statistics and lock-qualification FSM
module cdr_lock_detector #(
  parameter int ERR_W        = 8,
  parameter int WIN_LEN      = 64,
  parameter int LOCK_THRESH  = 2,
  parameter int GOOD_MIN     = 56,
  parameter int ACQ_WINDOWS  = 4,
  parameter int LOSS_WINDOWS = 2,
  parameter int CNT_W        = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_enable,
  input  logic signed [ERR_W-1:0]          i_phase_error,
  input  logic                             i_clear_stats,
  output logic                             o_locked,
  output logic [1:0]                       o_lock_state,
  output logic                             o_window_done,
  output logic [$clog2(WIN_LEN+1)-1:0]     o_last_good_count,
  output logic [ERR_W:0]                   o_max_abs_err,
  output logic [CNT_W-1:0]                 o_lock_loss_count
);

  localparam int IDX_W = $clog2(WIN_LEN);
  localparam int GC_W  = $clog2(WIN_LEN + 1);
  localparam int AW    = ERR_W + 1;
  localparam int AR_W  = $clog2(ACQ_WINDOWS + 1);
  localparam int LR_W  = $clog2(LOSS_WINDOWS + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_ACQUIRING = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_HOLDOVER  = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic [AR_W-1:0]   r_acq_run, w_acq_run_next;
  logic [LR_W-1:0]   r_loss_run, w_loss_run_next;
  logic              w_loss_event;
  logic              r_locked;

  logic [IDX_W-1:0]  r_idx;
  logic [GC_W-1:0]   r_good_cnt;
  logic [AW-1:0]     r_peak;
  logic              r_window_done;
  logic [GC_W-1:0]   r_last_good_count;
  logic [AW-1:0]     r_max_abs_err;
  logic [CNT_W-1:0]  r_lock_loss_count;

  // Widen before negating so the most negative error maps to a positive magnitude.
  logic signed [AW-1:0] w_err_ext;
  logic [AW-1:0]        w_abs;
  logic                 w_good_sample;
  logic                 w_close;
  logic [GC_W-1:0]      w_cnt_total;
  logic [AW-1:0]        w_peak_total;
  logic                 w_good_window;

  assign w_err_ext     = AW'(i_phase_error);
  assign w_abs         = w_err_ext[AW-1] ? AW'(-w_err_ext) : AW'(w_err_ext);
  assign w_good_sample = (w_abs <= AW'(LOCK_THRESH));
  assign w_close       = i_enable && (r_idx == IDX_W'(WIN_LEN - 1));
  assign w_cnt_total   = r_good_cnt + GC_W'(w_good_sample);
  assign w_peak_total  = (w_abs > r_peak) ? w_abs : r_peak;
  assign w_good_window = (w_cnt_total >= GC_W'(GOOD_MIN));

  always_comb begin
    w_state_next    = r_state;
    w_acq_run_next  = r_acq_run;
    w_loss_run_next = r_loss_run;
    w_loss_event    = 1'b0;
    if (w_close) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_good_window) begin
            if (ACQ_WINDOWS == 1) begin
              w_state_next   = ST_LOCKED;
              w_acq_run_next = '0;
            end else begin
              w_state_next   = ST_ACQUIRING;
              w_acq_run_next = AR_W'(1);
            end
          end
        end
        ST_ACQUIRING: begin
          if (!w_good_window) begin
            w_state_next   = ST_UNLOCKED;
            w_acq_run_next = '0;
          end else if (int'(r_acq_run) + 1 >= ACQ_WINDOWS) begin
            w_state_next   = ST_LOCKED;
            w_acq_run_next = '0;
          end else begin
            w_acq_run_next = r_acq_run + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_good_window) begin
            if (LOSS_WINDOWS == 1) begin
              w_state_next = ST_UNLOCKED;
              w_loss_event = 1'b1;
            end else begin
              w_state_next    = ST_HOLDOVER;
              w_loss_run_next = LR_W'(1);
            end
          end
        end
        default: begin
          if (w_good_window) begin
            w_state_next    = ST_LOCKED;
            w_loss_run_next = '0;
          end else if (int'(r_loss_run) + 1 >= LOSS_WINDOWS) begin
            w_state_next    = ST_UNLOCKED;
            w_loss_run_next = '0;
            w_loss_event    = 1'b1;
          end else begin
            w_loss_run_next = r_loss_run + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_UNLOCKED;
      r_acq_run  <= '0;
      r_loss_run <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_acq_run  <= w_acq_run_next;
      r_loss_run <= w_loss_run_next;
      r_locked   <= (w_state_next == ST_LOCKED) || (w_state_next == ST_HOLDOVER);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx             <= '0;
      r_good_cnt        <= '0;
      r_peak            <= '0;
      r_window_done     <= 1'b0;
      r_last_good_count <= '0;
      r_max_abs_err     <= '0;
      r_lock_loss_count <= '0;
    end else begin
      r_window_done <= 1'b0;
      if (i_enable) begin
        if (w_close) begin
          r_idx             <= '0;
          r_good_cnt        <= '0;
          r_peak            <= '0;
          r_window_done     <= 1'b1;
          r_last_good_count <= w_cnt_total;
          r_max_abs_err     <= w_peak_total;
        end else begin
          r_idx      <= r_idx + 1'b1;
          r_good_cnt <= w_cnt_total;
          r_peak     <= w_peak_total;
        end
      end
      if (w_loss_event && (r_lock_loss_count != {CNT_W{1'b1}})) begin
        r_lock_loss_count <= r_lock_loss_count + 1'b1;
      end
      // Clearing overrides both the window-close load and a same-cycle loss increment.
      if (i_clear_stats) begin
        r_max_abs_err     <= '0;
        r_lock_loss_count <= '0;
      end
    end
  end

  assign o_locked          = r_locked;
  assign o_lock_state      = r_state;
  assign o_window_done     = r_window_done;
  assign o_last_good_count = r_last_good_count;
  assign o_max_abs_err     = r_max_abs_err;
  assign o_lock_loss_count = r_lock_loss_count;

endmodule
